// File: rtl/edge_zbt_writer.sv
// Re-aligns edge-detector pixels to their raster position, packs two 18-bit pixels per
// 36-bit ZBT word, and writes one armed frame to ZBT through a small FIFO and grant handshake.
module edge_zbt_writer #(
  parameter int PIPE_DELAY   = 6,
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 19,
  parameter int BASE_ADDR    = 0,
  parameter int MASK_NONEDGE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [23:0]       pix_in,
  input  logic              sel_in,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              frame_en,
  input  logic              wr_grant,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [35:0]       wr_data,
  output logic              busy,
  output logic              overflow,
  output logic              frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [10:0]       H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]        V_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [AW:0]       PTR_ONE = (AW+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [35:0]       data;
  } entry_t;

  state_t state_q, state_d;
  logic [PIPE_DELAY-1:0][10:0] hd_q;
  logic [PIPE_DELAY-1:0][9:0]  vd_q;
  logic [10:0]       dh;
  logic [9:0]        dv;
  logic [17:0]       q, lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ovf_q, done_q, done_d;
  entry_t [FIFO_DEPTH-1:0] mem_q;
  logic [AW:0]       wp_q, rp_q;
  entry_t            push_e, head;
  logic active, at_origin, last_px, push, pop, do_push, empty, full;
  logic unused_pix;

  assign unused_pix = ^{pix_in[17:16], pix_in[9:8], pix_in[1:0]};

  // hcount/vcount delay lines so dh/dv line up with pix_in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hd_q <= '0;
      vd_q <= '0;
    end else begin
      hd_q[0] <= hcount;
      vd_q[0] <= vcount;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hd_q[i] <= hd_q[i-1];
        vd_q[i] <= vd_q[i-1];
      end
    end
  end

  assign dh        = hd_q[PIPE_DELAY-1];
  assign dv        = vd_q[PIPE_DELAY-1];
  assign active    = (dh <= H_LAST) && (dv <= V_LAST);
  assign at_origin = (dh == 11'd0) && (dv == 10'd0);
  assign last_px   = (dh == H_LAST) && (dv == V_LAST);
  assign q         = (MASK_NONEDGE != 0 && !sel_in) ? 18'h0
                   : {pix_in[23:18], pix_in[15:10], pix_in[7:2]};
  assign push      = (state_q == CAPTURE) && active && dh[0];

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop     = !empty && wr_grant;
  assign do_push = push && (!full || pop);
  assign push_e  = '{addr: addr_q, data: {q, lo_q}};
  assign head    = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      addr_q  <= ADDR_BASE;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (active && !dh[0]) lo_q <= q;
      // Counter advances on every push attempt so dropped words leave a gap, not a shift.
      if (state_q == ARMED && state_d == CAPTURE) addr_q <= ADDR_BASE;
      else if (push)                              addr_q <= addr_q + ADDR_ONE;
      if (state_q != ARMED && state_d == ARMED)   ovf_q <= 1'b0;
      else if (push && full && !pop)              ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q[AW-1:0]] <= push_e;
        wp_q                <= wp_q + PTR_ONE;
      end
      if (pop) rp_q <= rp_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_en)          state_d = ARMED;
      ARMED:   if (at_origin)         state_d = CAPTURE;
      CAPTURE: if (push && last_px)   state_d = DRAIN;
      DRAIN:   if (empty)             state_d = frame_en ? ARMED : IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done_d = (state_q == DRAIN) && empty;
  end

  assign wr_req     = !empty;
  assign wr_addr    = head.addr;
  assign wr_data    = head.data;
  assign overflow   = ovf_q;
  assign frame_done = done_q;

endmodule
